// File: rtl/iobuf_bank_pkg.sv
// iobuf_bank_pkg: shared FSM encoding, widths and helpers for the
// registered bidirectional pad bank.
package iobuf_bank_pkg;

  localparam int STATE_W = 2;
  localparam int CNT_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    RX  = 2'd0,
    R2T = 2'd1,
    TX  = 2'd2,
    T2R = 2'd3
  } state_t;

  // Counter preload for a turnaround of 'turn' high-Z cycles; the FSM
  // leaves the turnaround state on the cycle the counter reads zero.
  function automatic logic [CNT_W-1:0] turn_load(input int turn);
    return (turn > 0) ? CNT_W'(turn - 1) : '0;
  endfunction

endpackage

// File: rtl/iobuf_sync.sv
// iobuf_sync: STAGES-deep flop chain with async active-low clear and a
// synchronous clear that wipes every stage at once.
module iobuf_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  // Shift the chain every cycle; a synchronous clear flushes all stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < STAGES; k++) r_chain[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < STAGES; k++) r_chain[k] <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int k = 1; k < STAGES; k++) r_chain[k] <= r_chain[k-1];
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/iobuf_bank_reg.sv
// iobuf_bank_reg: registered bidirectional pad bank with a turnaround FSM
// so neither side ever drives the pads at the same time as the other.
// Optional feature: define IOBUF_BANK_LOOPBACK_EN to add the LPBK input,
// which parks the pads at high-Z and feeds the transmit register straight
// into the receive synchroniser.
//
// state | meaning
// RX    | pads high-Z, receiving; O_VALID asserts once the synchroniser settles
// R2T   | high-Z turnaround before driving; T_REQ=1 aborts back to RX
// TX    | pads driven from the transmit register (unless GTS/LPBK)
// T2R   | high-Z turnaround after driving; always runs to completion
module iobuf_bank_reg
  import iobuf_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             GTS,
  input  logic [WIDTH-1:0] I,
  input  logic             T_REQ,
`ifdef IOBUF_BANK_LOOPBACK_EN
  input  logic             LPBK,
`endif
  inout  wire  [WIDTH-1:0] IO,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  output logic             T_STAT,
  output logic             BUSY
);

  if (TURN_CYCLES < 0 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("iobuf_bank_reg: TURN_CYCLES must be in 0..15");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("iobuf_bank_reg: SYNC_STAGES must be at least 2");
  end

  localparam logic [CNT_W-1:0] TURN_LOAD = turn_load(TURN_CYCLES);
  localparam bit               TURN_ZERO = (TURN_CYCLES == 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_tx;
  logic             w_drive;
  logic             w_in_rx;
  logic             w_leave_rx;
  logic [WIDTH-1:0] w_sync_d;

  // State and turnaround counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= RX;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Transmit register follows I every cycle, whatever the direction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_tx <= '0;
    else        r_tx <= I;
  end

  // Next-state logic: direction changes pass through a high-Z turnaround.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RX: begin
        if (!T_REQ) begin
          if (TURN_ZERO) begin
            w_state_nxt = TX;
          end else begin
            w_state_nxt = R2T;
            w_cnt_nxt   = TURN_LOAD;
          end
        end
      end
      R2T: begin
        if (T_REQ) begin
          w_state_nxt = RX;
        end else if (r_cnt == '0) begin
          w_state_nxt = TX;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      TX: begin
        if (T_REQ) begin
          if (TURN_ZERO) begin
            w_state_nxt = RX;
          end else begin
            w_state_nxt = T2R;
            w_cnt_nxt   = TURN_LOAD;
          end
        end
      end
      T2R: begin
        if (r_cnt == '0) w_state_nxt = RX;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: begin
        w_state_nxt = RX;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the registered state; GTS only gates the pad drive.
  always_comb begin
    T_STAT     = (r_state != TX);
    BUSY       = (r_state == R2T) || (r_state == T2R);
    w_in_rx    = (r_state == RX);
    w_leave_rx = w_in_rx && (w_state_nxt != RX);
`ifdef IOBUF_BANK_LOOPBACK_EN
    w_drive    = (r_state == TX) && !GTS && !LPBK;
    w_sync_d   = LPBK ? r_tx : IO;
`else
    w_drive    = (r_state == TX) && !GTS;
    w_sync_d   = IO;
`endif
  end

  assign IO = w_drive ? r_tx : {WIDTH{1'bz}};

  iobuf_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync_data (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clr   (1'b0),
    .i_d     (w_sync_d),
    .o_q     (O)
  );

  // The valid chain is flushed on the edge that leaves RX so O_VALID drops
  // at once instead of draining.
  iobuf_sync #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_sync_valid (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clr   (w_leave_rx),
    .i_d     (w_in_rx),
    .o_q     (O_VALID)
  );

endmodule

// File: tb/tb_iobuf_bank_reg.sv
// tb_iobuf_bank_reg: per-cycle scoreboard against a direction/turnaround
// model of the pad bank. The far side drives the pads whenever the model
// says this side should not, so any stray drive corrupts the pad value.
module tb_iobuf_bank_reg;

  localparam int W    = 8;
  localparam int TURN = 2;
  localparam int SYNC = 2;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         gts     = 1'b0;
  logic         treq    = 1'b1;
  logic [W-1:0] din     = '0;
  logic         far_en  = 1'b1;
  logic [W-1:0] far_val = '0;
  wire  [W-1:0] io;
  logic [W-1:0] o;
  logic         o_valid;
  logic         t_stat;
  logic         busy;
`ifdef IOBUF_BANK_LOOPBACK_EN
  logic         lpbk    = 1'b0;
`endif

  assign io = far_en ? far_val : {W{1'bz}};

  iobuf_bank_reg #(
    .WIDTH       (W),
    .TURN_CYCLES (TURN),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .GTS     (gts),
    .I       (din),
    .T_REQ   (treq),
`ifdef IOBUF_BANK_LOOPBACK_EN
    .LPBK    (lpbk),
`endif
    .IO      (io),
    .O       (o),
    .O_VALID (o_valid),
    .T_STAT  (t_stat),
    .BUSY    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] o;
    logic         ov;
    logic         ts;
    logic         bz;
    logic [W-1:0] io;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: "driving" plus a remaining-turnaround count with a
  // target direction; receive data is a plain history of pad values.
  bit           m_drv;
  int           m_turn;
  bit           m_to_tx;
  logic [W-1:0] m_txr;
  logic [W-1:0] m_hist[$];
  int           m_rx_age;
  logic [W-1:0] m_pad;

  function automatic bit m_in_rx();
    return !m_drv && (m_turn == 0);
  endfunction

  function automatic void model_reset();
    m_drv    = 1'b0;
    m_turn   = 0;
    m_to_tx  = 1'b0;
    m_txr    = '0;
    m_rx_age = 0;
    m_hist.delete();
    for (int k = 0; k < SYNC; k++) m_hist.push_back('0);
  endfunction

  function automatic void model_edge(input bit treq_v, input logic [W-1:0] i_v,
                                     input logic [W-1:0] pad_v);
    bit was_rx;
    was_rx = m_in_rx();
    m_hist.push_back(pad_v);
    void'(m_hist.pop_front());
    m_txr = i_v;
    if (m_drv) begin
      if (treq_v) begin
        m_drv   = 1'b0;
        m_turn  = TURN;
        m_to_tx = 1'b0;
      end
    end else if (m_turn > 0) begin
      if (m_to_tx && treq_v) begin
        m_turn = 0;
      end else begin
        m_turn--;
        if (m_turn == 0 && m_to_tx) m_drv = 1'b1;
      end
    end else if (!treq_v) begin
      if (TURN == 0) begin
        m_drv = 1'b1;
      end else begin
        m_turn  = TURN;
        m_to_tx = 1'b1;
      end
    end
    if (was_rx && m_in_rx()) m_rx_age++;
    else                     m_rx_age = 0;
  endfunction

  task automatic apply(input logic [W-1:0] i_v, input bit treq_v, input bit gts_v,
                       input logic [W-1:0] far_v, input string tag);
    exp_t e;
    bit   drv;
    din     = i_v;
    treq    = treq_v;
    gts     = gts_v;
    drv     = m_drv && !gts_v;
    far_val = far_v;
    far_en  = !drv;
    e.o   = m_hist[0];
    e.ov  = m_in_rx() && (m_rx_age >= SYNC);
    e.ts  = !m_drv;
    e.bz  = (m_turn > 0);
    e.io  = drv ? m_txr : far_v;
    e.tag = tag;
    m_pad = e.io;
    sb.push_back(e);
  endtask

  // mode 0: normal cycle, 1: assert reset mid-cycle, 2: release reset mid-cycle
  task automatic cycle(input logic [W-1:0] i_v, input bit treq_v, input bit gts_v,
                       input int mode, input logic [W-1:0] far_v, input string tag);
    @(posedge clk);
    if (rst_n) model_edge(treq, din, m_pad);
    if (mode == 1) begin
      #2;
      rst_n = 1'b0;
      model_reset();
    end else begin
      #1;
      if (mode == 2) rst_n = 1'b1;
    end
    apply(i_v, treq_v, gts_v, far_v, tag);
  endtask

  task automatic chk(input string tag, input string field,
                     input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got %h want %h at %0t", tag, field, got, want, $time);
    end
  endtask

  exp_t mon_e;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, "O",       o,                  mon_e.o);
      chk(mon_e.tag, "O_VALID", W'(o_valid),        W'(mon_e.ov));
      chk(mon_e.tag, "T_STAT",  W'(t_stat),         W'(mon_e.ts));
      chk(mon_e.tag, "BUSY",    W'(busy),           W'(mon_e.bz));
      chk(mon_e.tag, "IO",      io,                 mon_e.io);
    end
  end

  initial begin
    bit           r_treq;
    bit           r_gts;
    logic [W-1:0] r_i;
    model_reset();
    m_pad = '0;

    cycle('0, 1'b1, 1'b0, 0, W'($urandom), "in_reset");
    cycle('0, 1'b1, 1'b0, 0, W'($urandom), "in_reset");
    cycle('0, 1'b1, 1'b0, 2, W'($urandom), "release");
    for (int k = 0; k < 5; k++) cycle('0, 1'b1, 1'b0, 0, W'($urandom), "idle_rx");

    for (int k = 0; k < 7; k++) cycle(8'hA5, 1'b0, 1'b0, 0, W'($urandom), "to_tx_a5");
    for (int k = 0; k < 7; k++) cycle(8'hA5, 1'b1, 1'b0, 0, 8'h3C, "to_rx_3c");

    for (int k = 0; k < 2; k++) cycle(8'h77, 1'b0, 1'b0, 0, W'($urandom), "abort_pulse");
    for (int k = 0; k < 4; k++) cycle(8'h77, 1'b1, 1'b0, 0, W'($urandom), "abort_rx");

    for (int k = 0; k < 5; k++) cycle(8'hFF, 1'b0, 1'b0, 0, 8'h00, "tx_ff");
    for (int k = 0; k < 3; k++) cycle(8'hFF, 1'b0, 1'b1, 0, 8'h00, "gts_on");
    for (int k = 0; k < 2; k++) cycle(8'hFF, 1'b0, 1'b0, 0, 8'h00, "gts_off");
    cycle(8'hFF, 1'b0, 1'b0, 1, 8'h00, "rst_mid_tx");
    cycle(8'hFF, 1'b0, 1'b0, 0, 8'h00, "rst_hold");
    cycle(8'hFF, 1'b1, 1'b0, 2, W'($urandom), "rst_release");
    for (int k = 0; k < 3; k++) cycle(8'h00, 1'b1, 1'b0, 0, W'($urandom), "post_rst");

    r_treq = 1'b1;
    r_gts  = 1'b0;
    for (int k = 0; k < 600; k++) begin
      r_i = W'($urandom);
      if ($urandom_range(0, 3) == 0) r_treq = ~r_treq;
      r_gts = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        cycle(r_i, r_treq, r_gts, 1, W'($urandom), "rand_rst");
        cycle(r_i, r_treq, r_gts, 2, W'($urandom), "rand_rel");
      end else begin
        cycle(r_i, r_treq, r_gts, 0, W'($urandom), "random");
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
